// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit buffer: the line-ending characters
// and the issue FSM state encoding.
package uart_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;  // waiting for a byte and an idle transmitter
    localparam state_t S_WAIT = 2'd1;  // strobe sent, waiting for busy to rise
    localparam state_t S_BUSY = 2'd2;  // frame in flight, waiting for busy to fall

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head and a registered
// occupancy counter. DEPTH must be a power of two so the pointers wrap freely.
module byte_fifo #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              pop,
    output logic [7:0]        head,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push is refused while full even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head  = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == (ADDR_W+1)'(DEPTH));

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and issue sequencer in front of the UART transmitter.
// Producers push over valid/ready; the FSM pops one byte per frame and
// strobes tx_start only while the transmitter reports idle.
// Optional build macro UART_TX_FIFO_CRLF_EN expands each LF into CR,LF.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_busy,
    output logic [ADDR_W:0] level,
    output logic            empty,
    output logic            full
);

    state_t     state;
    logic [7:0] head;
    logic       issue;
    logic       do_pop;
    logic [7:0] issue_byte;

    assign in_ready = ~full;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid & in_ready),
        .din   (in_data),
        .pop   (do_pop),
        .head  (head),
        .level (level),
        .empty (empty),
        .full  (full)
    );

`ifdef UART_TX_FIFO_CRLF_EN
    logic lf_pending;
    logic insert_cr;

    // An LF at the head first goes out as CR (kept in the FIFO), then as LF.
    always_comb begin
        issue      = (state == S_IDLE) && !empty && !tx_busy;
        insert_cr  = (head == CHAR_LF) && !lf_pending;
        do_pop     = issue && !insert_cr;
        issue_byte = insert_cr ? CHAR_CR : head;
    end

    // Remembers that the CR for the current head LF has already been sent.
    always_ff @(posedge clk) begin
        if (rst)
            lf_pending <= 1'b0;
        else if (issue)
            lf_pending <= insert_cr;
    end
`else
    // Issue whenever a byte is queued and the transmitter is idle.
    always_comb begin
        issue      = (state == S_IDLE) && !empty && !tx_busy;
        do_pop     = issue;
        issue_byte = head;
    end
`endif

    // Issue FSM: strobe, wait for busy to rise, then wait for it to fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        tx_data  <= issue_byte;
                        tx_start <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_busy)
                        state <= S_BUSY;
                end
                S_BUSY: begin
                    if (!tx_busy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter whose busy
// rises the cycle after it samples tx_start and lasts BUSY_LEN cycles.
module tb_uart_tx_fifo;

    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [4:0] level;
    logic       empty;
    logic       full;

    int         busy_cnt = 0;
    logic       hold_busy = 1'b0;
    logic       prev_start = 1'b0;
    logic       seen_busy = 1'b1;
    int         strobes = 0;
    int         viol = 0;
    logic [7:0] rxq [$];
    logic [7:0] expq [$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign tx_busy = hold_busy | (busy_cnt != 0);

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .level    (level),
        .empty    (empty),
        .full     (full)
    );

    // Transmitter model plus strobe-rule monitor (no strobe while busy,
    // never back-to-back, always a busy period between strobes).
    always @(posedge clk) begin
        if (tx_start) begin
            rxq.push_back(tx_data);
            strobes  <= strobes + 1;
            busy_cnt <= BUSY_LEN;
            viol     <= viol + int'(tx_busy) + int'(prev_start) + int'(!seen_busy);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        seen_busy  <= tx_start ? 1'b0 : (seen_busy | tx_busy);
        prev_start <= tx_start;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < 3000) begin
            tick();
            n++;
            if (empty && busy_cnt == 0 && !tx_start && !hold_busy) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 32'(rxq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        int base;
        int n;
        logic seen_full;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();

        // Reset values
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Single byte latency: push in cycle 0, strobe in cycle 2
        base     = strobes;
        in_valid = 1'b1;
        in_data  = 8'h41;
        tick();
        in_valid = 1'b0;
        chk("lat_c1_level", 32'(level),    32'd1);
        chk("lat_c1_start", 32'(tx_start), 32'd0);
        tick();
        chk("lat_c2_start", 32'(tx_start), 32'd1);
        chk("lat_c2_data",  32'(tx_data),  32'h41);
        chk("lat_c2_level", 32'(level),    32'd0);
        tick();
        chk("lat_c3_start", 32'(tx_start), 32'd0);
        wait_idle("lat");
        chk("lat_strobes", 32'(strobes - base), 32'd1);
        expq.push_back(8'h41);
        check_rx("lat_rx");

        // Full-rate burst of 20 bytes into a 16-deep FIFO
        seen_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            n = 0;
            while (!in_ready && n < 500) begin
                if (!seen_full) begin
                    chk("burst_full_level", 32'(level), 32'd16);
                    chk("burst_full_flag",  32'(full),  32'd1);
                    seen_full = 1'b1;
                end
                tick();
                n++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("burst_saw_full", 32'(seen_full), 32'd1);
        wait_idle("burst");
        for (int i = 0; i < 20; i++) expq.push_back(8'(i));
        check_rx("burst_rx");
        chk("burst_end_level", 32'(level), 32'd0);

        // Boundaries 0, 1, 15, 16; then pop with a refused push while full
        hold_busy = 1'b1;
        tick();
        chk("bnd0_empty", 32'(empty), 32'd1);
        chk("bnd0_full",  32'(full),  32'd0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            tick();
            if (i == 0) begin
                chk("bnd1_level", 32'(level), 32'd1);
                chk("bnd1_empty", 32'(empty), 32'd0);
            end
            if (i == 14) begin
                chk("bnd15_full",  32'(full),     32'd0);
                chk("bnd15_ready", 32'(in_ready), 32'd1);
            end
            if (i == 15) begin
                chk("bnd16_level", 32'(level),    32'd16);
                chk("bnd16_full",  32'(full),     32'd1);
                chk("bnd16_ready", 32'(in_ready), 32'd0);
            end
        end
        in_data   = 8'hEE;
        hold_busy = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("fullpop_level", 32'(level),    32'd15);
        chk("fullpop_start", 32'(tx_start), 32'd1);
        chk("fullpop_data",  32'(tx_data),  32'h80);
        wait_idle("bnd");
        for (int i = 0; i < 16; i++) expq.push_back(8'(8'h80 + i));
        check_rx("bnd_rx");

        // Simultaneous push and pop at level 5
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
        chk("pp_pre_level", 32'(level), 32'd5);
        in_valid  = 1'b1;
        in_data   = 8'h65;
        hold_busy = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("pp_level", 32'(level),    32'd5);
        chk("pp_start", 32'(tx_start), 32'd1);
        wait_idle("pp");
        for (int i = 0; i < 6; i++) expq.push_back(8'(8'h60 + i));
        check_rx("pp_rx");

        // Busy held for 50 cycles with 3 bytes queued
        hold_busy = 1'b1;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        base = strobes;
        repeat (50) tick();
        chk("hold_no_strobe", 32'(strobes - base), 32'd0);
        hold_busy = 1'b0;
        chk("hold_release_start", 32'(tx_start), 32'd0);
        tick();
        chk("hold_first_start", 32'(tx_start), 32'd1);
        chk("hold_first_data",  32'(tx_data),  32'h31);
        wait_idle("hold");
        expq.push_back(8'h31);
        expq.push_back(8'h32);
        expq.push_back(8'h33);
        check_rx("hold_rx");

        // Reset mid-frame with 8 bytes queued
        for (int i = 0; i < 9; i++) push_byte(8'(8'hA0 + i));
        chk("mid_level", 32'(level),   32'd8);
        chk("mid_busy",  32'(tx_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", 32'(level),    32'd0);
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        chk("mid_rst_empty", 32'(empty),    32'd1);
        base = strobes;
        n = 0;
        while (busy_cnt != 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (20) tick();
        chk("mid_no_strobe", 32'(strobes - base), 32'd0);
        push_byte(8'h5A);
        wait_idle("mid");
        expq.push_back(8'hA0);
        expq.push_back(8'h5A);
        check_rx("mid_rx");

        // Line-ending handling
        push_byte(8'h48);
        push_byte(8'h0A);
        push_byte(8'h0D);
        wait_idle("crlf");
        expq.push_back(8'h48);
`ifdef UART_TX_FIFO_CRLF_EN
        expq.push_back(8'h0D);
`endif
        expq.push_back(8'h0A);
        expq.push_back(8'h0D);
        check_rx("crlf_rx");
        chk("crlf_level", 32'(level), 32'd0);

        chk("strobe_rules", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
